// File: rtl/clock_pkg.sv
// Shared widths, field limits, alarm reset setpoint and BCD helpers for the timekeeping stage.
package clock_pkg;

  localparam int unsigned BCD_W   = 8;
  localparam int unsigned DIG_W   = 4;
  localparam int unsigned SEC_MAX = 59;
  localparam int unsigned MIN_MAX = 59;
  localparam int unsigned HR_MAX  = 23;

  localparam logic [BCD_W-1:0] ALM_HR_RST  = 8'h07;
  localparam logic [BCD_W-1:0] ALM_MIN_RST = 8'h00;

  typedef enum logic {
    ADJ_TIME  = 1'b0,
    ADJ_ALARM = 1'b1
  } adj_sel_e;

  function automatic logic [BCD_W-1:0] to_bcd(input int unsigned n);
    return {DIG_W'(n / 10), DIG_W'(n % 10)};
  endfunction

  // Two-digit BCD increment that wraps to 00 after max.
  function automatic logic [BCD_W-1:0] bcd_inc(input logic [BCD_W-1:0] v, input int unsigned max);
    if (v == to_bcd(max)) return '0;
    if (v[DIG_W-1:0] == DIG_W'(9)) return {v[BCD_W-1:DIG_W] + DIG_W'(1), DIG_W'(0)};
    return {v[BCD_W-1:DIG_W], v[DIG_W-1:0] + DIG_W'(1)};
  endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter wrapping at MAX; carry is combinational so fields can cascade in one cycle.
module bcd_mod_counter
  import clock_pkg::*;
#(
  parameter int unsigned      MAX     = 59,
  parameter logic [BCD_W-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [BCD_W-1:0] value,
  output logic             carry
);

  assign carry = inc & (value == to_bcd(MAX));

  always_ff @(posedge clk) begin
    if (rst) begin
      value <= RST_VAL;
    end else if (clr) begin
      value <= '0;
    end else if (inc) begin
      value <= bcd_inc(value, MAX);
    end
  end

endmodule

// File: rtl/time_keeper.sv
// 24-hour BCD clock advanced by rising edges of the divider output, with time/alarm adjust.
// Alarm setpoint, comparator and hold timer are built only when ALARM_EN is defined.
module time_keeper
  import clock_pkg::*;
#(
  parameter int unsigned TICKS_PER_SEC  = 1,
  parameter int unsigned ALARM_HOLD_SEC = 60
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_in,
  input  logic             run,
  input  logic             adj_sel,
  input  logic             adj_min,
  input  logic             adj_hr,
  input  logic             alarm_on,
  output logic [BCD_W-1:0] hr_bcd,
  output logic [BCD_W-1:0] min_bcd,
  output logic [BCD_W-1:0] sec_bcd,
  output logic             sec_pulse,
  output logic [BCD_W-1:0] alm_hr_bcd,
  output logic [BCD_W-1:0] alm_min_bcd,
  output logic             alarm
);

  localparam int unsigned PRE_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;

  logic             tick_d;
  logic [PRE_W-1:0] presc;
  logic             tick_edge_c;
  logic             adj_min_t_c;
  logic             adj_hr_t_c;
  logic             time_adj_c;
  logic             tick_ok_c;
  logic             presc_wrap_c;
  logic             adv_c;
  logic             sec_carry;
  logic             min_carry;
  logic             hr_carry_unused;

  assign tick_edge_c  = tick_in & ~tick_d;
  assign adj_min_t_c  = adj_min & (adj_sel == ADJ_TIME);
  assign adj_hr_t_c   = adj_hr & (adj_sel == ADJ_TIME);
  assign time_adj_c   = adj_min_t_c | adj_hr_t_c;
  // A time adjust in the same cycle swallows the tick edge entirely.
  assign tick_ok_c    = tick_edge_c & run & ~time_adj_c;
  assign presc_wrap_c = (presc == PRE_W'(TICKS_PER_SEC - 1));
  assign adv_c        = tick_ok_c & presc_wrap_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_d    <= 1'b0;
      presc     <= '0;
      sec_pulse <= 1'b0;
    end else begin
      tick_d    <= tick_in;
      sec_pulse <= adv_c;
      if (adj_min_t_c) begin
        presc <= '0;
      end else if (tick_ok_c) begin
        presc <= presc_wrap_c ? '0 : presc + 1'b1;
      end
    end
  end

  bcd_mod_counter #(.MAX(SEC_MAX)) u_sec (
    .clk   (clk),
    .rst   (rst),
    .inc   (adv_c),
    .clr   (adj_min_t_c),
    .value (sec_bcd),
    .carry (sec_carry)
  );

  bcd_mod_counter #(.MAX(MIN_MAX)) u_min (
    .clk   (clk),
    .rst   (rst),
    .inc   (sec_carry | adj_min_t_c),
    .clr   (1'b0),
    .value (min_bcd),
    .carry (min_carry)
  );

  // Minute wrap from an adjust must not reach the hours, so gate with the tick carry.
  bcd_mod_counter #(.MAX(HR_MAX)) u_hr (
    .clk   (clk),
    .rst   (rst),
    .inc   ((min_carry & sec_carry) | adj_hr_t_c),
    .clr   (1'b0),
    .value (hr_bcd),
    .carry (hr_carry_unused)
  );

`ifdef ALARM_EN
  localparam int unsigned HOLD_W = (ALARM_HOLD_SEC > 1) ? $clog2(ALARM_HOLD_SEC) : 1;

  logic              alm_min_carry_unused;
  logic              alm_hr_carry_unused;
  logic [BCD_W-1:0]  next_min_c;
  logic [BCD_W-1:0]  next_hr_c;
  logic              trig_c;
  logic [HOLD_W-1:0] hold_cnt;

  bcd_mod_counter #(.MAX(MIN_MAX), .RST_VAL(ALM_MIN_RST)) u_alm_min (
    .clk   (clk),
    .rst   (rst),
    .inc   (adj_min & (adj_sel == ADJ_ALARM)),
    .clr   (1'b0),
    .value (alm_min_bcd),
    .carry (alm_min_carry_unused)
  );

  bcd_mod_counter #(.MAX(HR_MAX), .RST_VAL(ALM_HR_RST)) u_alm_hr (
    .clk   (clk),
    .rst   (rst),
    .inc   (adj_hr & (adj_sel == ADJ_ALARM)),
    .clr   (1'b0),
    .value (alm_hr_bcd),
    .carry (alm_hr_carry_unused)
  );

  // Compare against the hh:mm the tick is about to produce; only a tick landing on :00 can fire.
  assign next_min_c = bcd_inc(min_bcd, MIN_MAX);
  assign next_hr_c  = (min_bcd == to_bcd(MIN_MAX)) ? bcd_inc(hr_bcd, HR_MAX) : hr_bcd;
  assign trig_c     = alarm_on & sec_carry &
                      (next_hr_c == alm_hr_bcd) & (next_min_c == alm_min_bcd);

  always_ff @(posedge clk) begin
    if (rst) begin
      alarm    <= 1'b0;
      hold_cnt <= '0;
    end else if (!alarm_on) begin
      alarm <= 1'b0;
    end else if (trig_c) begin
      alarm    <= 1'b1;
      hold_cnt <= '0;
    end else if (alarm && adv_c) begin
      if (hold_cnt == HOLD_W'(ALARM_HOLD_SEC - 1)) begin
        alarm <= 1'b0;
      end else begin
        hold_cnt <= hold_cnt + 1'b1;
      end
    end
  end
`else
  logic cfg_unused;

  assign cfg_unused  = alarm_on | (ALARM_HOLD_SEC == 0);
  assign alarm       = 1'b0;
  assign alm_hr_bcd  = '0;
  assign alm_min_bcd = '0;
`endif

endmodule

// File: tb/tb_time_keeper.sv
// Randomized and directed bench for time_keeper against a seconds-of-day reference model.
module tb_time_keeper;

  localparam int unsigned TPS  = 2;
  localparam int unsigned HOLD = 60;
`ifdef ALARM_EN
  localparam bit ALM_BUILT = 1'b1;
`else
  localparam bit ALM_BUILT = 1'b0;
`endif

  bit   clk = 1'b0;
  logic rst, tick_in, run, adj_sel, adj_min, adj_hr, alarm_on;
  logic [7:0] hr_bcd, min_bcd, sec_bcd, alm_hr_bcd, alm_min_bcd;
  logic sec_pulse, alarm;

  int nvec = 0;
  int nfail = 0;
  bit chk_en = 1'b0;

  time_keeper #(.TICKS_PER_SEC(TPS), .ALARM_HOLD_SEC(HOLD)) dut (
    .clk         (clk),
    .rst         (rst),
    .tick_in     (tick_in),
    .run         (run),
    .adj_sel     (adj_sel),
    .adj_min     (adj_min),
    .adj_hr      (adj_hr),
    .alarm_on    (alarm_on),
    .hr_bcd      (hr_bcd),
    .min_bcd     (min_bcd),
    .sec_bcd     (sec_bcd),
    .sec_pulse   (sec_pulse),
    .alm_hr_bcd  (alm_hr_bcd),
    .alm_min_bcd (alm_min_bcd),
    .alarm       (alarm)
  );

  always #5 clk = ~clk;

  // Reference state: time as seconds of day, setpoint as minutes of day.
  int m_t, m_presc, m_sp, m_hold;
  bit m_tick_d, m_pulse, m_alarm;

  function automatic logic [7:0] bcd(input int n);
    return {4'(n / 10), 4'(n % 10)};
  endfunction

  task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin : model
    bit edge_s, tadj, adv;
    int h, mi, s, old_sp;
    if (rst) begin
      m_t = 0; m_presc = 0; m_sp = 7 * 60; m_hold = 0;
      m_tick_d = 0; m_pulse = 0; m_alarm = 0;
    end else begin
      edge_s   = tick_in && !m_tick_d;
      m_tick_d = tick_in;
      tadj     = !adj_sel && (adj_min || adj_hr);
      adv      = 0;
      old_sp   = m_sp;
      if (tadj) begin
        h = m_t / 3600; mi = (m_t / 60) % 60; s = m_t % 60;
        if (adj_min) begin mi = (mi + 1) % 60; s = 0; m_presc = 0; end
        if (adj_hr) h = (h + 1) % 24;
        m_t = h * 3600 + mi * 60 + s;
      end else if (edge_s && run) begin
        if (m_presc == TPS - 1) begin
          m_presc = 0;
          m_t = (m_t + 1) % 86400;
          adv = 1;
        end else begin
          m_presc++;
        end
      end
      m_pulse = adv;
      if (ALM_BUILT) begin
        if (adj_sel) begin
          h = m_sp / 60; mi = m_sp % 60;
          if (adj_min) mi = (mi + 1) % 60;
          if (adj_hr) h = (h + 1) % 24;
          m_sp = h * 60 + mi;
        end
        if (!alarm_on) m_alarm = 0;
        else if (adv && (m_t % 60 == 0) && (m_t / 60 == old_sp)) begin
          m_alarm = 1;
          m_hold = HOLD;
        end else if (m_alarm && adv) begin
          m_hold--;
          if (m_hold == 0) m_alarm = 0;
        end
      end
    end
  end

  always @(negedge clk) begin : compare
    if (chk_en) begin
      cmp("hr", hr_bcd, bcd(m_t / 3600));
      cmp("min", min_bcd, bcd((m_t / 60) % 60));
      cmp("sec", sec_bcd, bcd(m_t % 60));
      cmp("sec_pulse", {7'd0, sec_pulse}, {7'd0, m_pulse});
      cmp("alm_hr", alm_hr_bcd, ALM_BUILT ? bcd(m_sp / 60) : 8'h00);
      cmp("alm_min", alm_min_bcd, ALM_BUILT ? bcd(m_sp % 60) : 8'h00);
      cmp("alarm", {7'd0, alarm}, {7'd0, m_alarm});
    end
  end

  task automatic pulse_tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk) tick_in = 1'b1;
      @(negedge clk) tick_in = 1'b0;
    end
  endtask

  task automatic pulse_adj(input logic sel, input logic m, input logic h, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk) begin adj_sel = sel; adj_min = m; adj_hr = h; end
      @(negedge clk) begin adj_min = 1'b0; adj_hr = 1'b0; adj_sel = 1'b0; end
    end
  endtask

  task automatic check_time(input string name, input logic [7:0] h, input logic [7:0] m,
                            input logic [7:0] s);
    cmp({name, ".hr"}, hr_bcd, h);
    cmp({name, ".min"}, min_bcd, m);
    cmp({name, ".sec"}, sec_bcd, s);
  endtask

  initial begin
    rst = 1'b1; tick_in = 1'b0; run = 1'b1; adj_sel = 1'b0;
    adj_min = 1'b0; adj_hr = 1'b0; alarm_on = 1'b0;
    @(negedge clk);
    @(negedge clk) begin rst = 1'b0; chk_en = 1'b1; end

    check_time("reset", 8'h00, 8'h00, 8'h00);
    cmp("reset.alm_hr", alm_hr_bcd, ALM_BUILT ? 8'h07 : 8'h00);
    cmp("reset.alm_min", alm_min_bcd, 8'h00);
    cmp("reset.sec_pulse", {7'd0, sec_pulse}, 8'h00);
    cmp("reset.alarm", {7'd0, alarm}, 8'h00);

    // Set 23:59:59 then roll over.
    pulse_adj(1'b0, 1'b0, 1'b1, 23);
    pulse_adj(1'b0, 1'b1, 1'b0, 59);
    pulse_tick(59 * TPS);
    check_time("preroll", 8'h23, 8'h59, 8'h59);
    pulse_tick(TPS);
    check_time("rollover", 8'h00, 8'h00, 8'h00);
    cmp("rollover.sec_pulse", {7'd0, sec_pulse}, 8'h01);
    @(negedge clk);
    cmp("rollover.pulse_end", {7'd0, sec_pulse}, 8'h00);

    // Long levels: four periods give four edges, i.e. two seconds.
    for (int p = 0; p < 4; p++) begin
      @(negedge clk) tick_in = 1'b1;
      repeat (9) @(negedge clk);
      @(negedge clk) tick_in = 1'b0;
      repeat (9) @(negedge clk);
    end
    check_time("edges", 8'h00, 8'h00, 8'h02);
    run = 1'b0;
    pulse_tick(8);
    check_time("frozen", 8'h00, 8'h00, 8'h02);
    run = 1'b1;

    // Build 12:59:30 with prescaler half way, then collide adj_min with an advancing edge.
    pulse_adj(1'b0, 1'b0, 1'b1, 12);
    pulse_adj(1'b0, 1'b1, 1'b0, 59);
    pulse_tick(30 * TPS + 1);
    check_time("pre_collide", 8'h12, 8'h59, 8'h30);
    @(negedge clk) begin tick_in = 1'b1; adj_min = 1'b1; end
    @(negedge clk) begin tick_in = 1'b0; adj_min = 1'b0; end
    check_time("collide", 8'h12, 8'h00, 8'h00);
    cmp("collide.sec_pulse", {7'd0, sec_pulse}, 8'h00);
    pulse_adj(1'b0, 1'b0, 1'b1, 11);
    pulse_adj(1'b0, 1'b1, 1'b0, 3);
    pulse_tick(4 * TPS);
    pulse_adj(1'b0, 1'b0, 1'b1, 1);
    check_time("hr_wrap", 8'h00, 8'h03, 8'h04);

    // Alarm at 00:01 reached by ticking from 00:00:59.
    pulse_adj(1'b0, 1'b1, 1'b0, 57);
    pulse_adj(1'b1, 1'b0, 1'b1, 17);
    pulse_adj(1'b1, 1'b1, 1'b0, 1);
    cmp("alm_set.hr", alm_hr_bcd, 8'h00);
    cmp("alm_set.min", alm_min_bcd, ALM_BUILT ? 8'h01 : 8'h00);
    alarm_on = 1'b1;
    pulse_tick(59 * TPS);
    check_time("pre_alarm", 8'h00, 8'h00, 8'h59);
    cmp("pre_alarm.alarm", {7'd0, alarm}, 8'h00);
    pulse_tick(TPS);
    check_time("alarm_hit", 8'h00, 8'h01, 8'h00);
    cmp("alarm_hit.alarm", {7'd0, alarm}, {7'd0, ALM_BUILT});
    pulse_tick((HOLD - 1) * TPS);
    cmp("alarm_hold.alarm", {7'd0, alarm}, {7'd0, ALM_BUILT});
    pulse_tick(TPS);
    cmp("alarm_expire.alarm", {7'd0, alarm}, 8'h00);
    pulse_adj(1'b1, 1'b1, 1'b0, 2);
    pulse_tick(60 * TPS);
    check_time("alarm2", 8'h00, 8'h03, 8'h00);
    cmp("alarm2.alarm", {7'd0, alarm}, {7'd0, ALM_BUILT});
    @(negedge clk) alarm_on = 1'b0;
    @(negedge clk);
    cmp("alarm_cancel.alarm", {7'd0, alarm}, 8'h00);

    // Reset while tick_in is high: the level still high afterwards is one fresh edge.
    pulse_tick(5 * TPS);
    @(negedge clk) begin tick_in = 1'b1; rst = 1'b1; end
    @(negedge clk);
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    check_time("mid_reset", 8'h00, 8'h00, 8'h00);
    @(negedge clk) tick_in = 1'b0;
    pulse_tick(1);
    check_time("post_reset", 8'h00, 8'h00, 8'h01);
    cmp("post_reset.sec_pulse", {7'd0, sec_pulse}, 8'h01);

    // Random traffic with the model checking every cycle.
    alarm_on = 1'b1;
    repeat (5000) begin
      @(negedge clk);
      rst      = ($urandom_range(0, 499) == 0);
      tick_in  = ($urandom_range(0, 2) == 0) ? ~tick_in : tick_in;
      run      = ($urandom_range(0, 15) != 0);
      adj_sel  = 1'($urandom_range(0, 1));
      adj_min  = ($urandom_range(0, 19) == 0);
      adj_hr   = ($urandom_range(0, 29) == 0);
      alarm_on = ($urandom_range(0, 99) == 0) ? ~alarm_on : alarm_on;
    end
    @(negedge clk);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
